scancode_decoder: RTL and testbench

SCANCODE_DECODER -- requirements
Module: scancode_decoder

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/event_fifo.sv | 73 +++++++
 rtl/scancode_decoder.sv | 94 +++++++++
 tb/tb_scancode_decoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode path.
// Holds the decoder state encoding, the set-2 prefix bytes, the list of
// bytes that never produce an event, and the layout of a decoded event word.
package ps2_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } dec_state_e;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    // Keyboard status/ack bytes that are neither keys nor prefixes.
    localparam int          NUM_DISCARD  = 7;
    localparam logic [55:0] DISCARD_LIST = {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    // Event word: {extended, released, code[7:0]}
    localparam int unsigned EV_WIDTH    = 10;
    localparam int unsigned EV_EXT_BIT  = 9;
    localparam int unsigned EV_REL_BIT  = 8;
    localparam int unsigned EV_CODE_MSB = 7;
    localparam int unsigned EV_CODE_LSB = 0;

    function automatic logic is_discard(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_DISCARD; i++) begin
            if (DISCARD_LIST[i*8 +: 8] == b) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO for decoded key events.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write wr_data (ignored when full unless a pop happens too)
//   wr_data    : entry to write
//   pop        : consume head (ignored when empty)
//   rd_data    : head entry, valid whenever empty is low
//   full/empty : occupancy flags
module event_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok, push_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only if the head leaves this cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/scancode_decoder.sv
// PS/2 set-2 scancode decoder with event FIFO.
// Synchronizes the receiver's frame-good level, decodes E0/F0 prefixes into
// {extended, released, code} events and queues them for a ready/valid consumer.
//   clk, rst  : clock, synchronous active-high reset
//   kbd_data  : last PS/2 byte (stable while kbd_valid is high)
//   kbd_valid : frame-good level from the ps2_clk domain
//   ev_data   : head event {ext, rel, code}
//   ev_valid  : FIFO not empty
//   ev_ready  : consumer accepts the head
//   overflow  : one-cycle pulse when a completed event is dropped
module scancode_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          kbd_data,
    input  logic                kbd_valid,
    output logic [EV_WIDTH-1:0] ev_data,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic                overflow
);

    logic       sync1_q, sync2_q, sync3_q;
    logic       strobe;
    dec_state_e state_q, state_d;
    logic       overflow_q, overflow_d;
    logic       emit;
    logic [EV_WIDTH-1:0] ev_new;
    logic       fifo_full, fifo_empty;

    // Sync flops reset high so a level already high at reset never strobes.
    assign strobe = sync2_q & ~sync3_q;

    // kbd_data is stable by protocol while the level is high, so it is used raw.
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        ev_new  = '0;
        if (strobe) begin
            if (kbd_data == PREFIX_EXT) begin
                if (state_q == S_IDLE) state_d = S_EXT;
            end else if (kbd_data == PREFIX_BRK) begin
                if (state_q == S_IDLE)     state_d = S_BRK;
                else if (state_q == S_EXT) state_d = S_EXT_BRK;
            end else if (!is_discard(kbd_data)) begin
                emit                              = 1'b1;
                ev_new[EV_EXT_BIT]                = (state_q == S_EXT) || (state_q == S_EXT_BRK);
                ev_new[EV_REL_BIT]                = (state_q == S_BRK) || (state_q == S_EXT_BRK);
                ev_new[EV_CODE_MSB:EV_CODE_LSB]   = kbd_data;
                state_d                           = S_IDLE;
            end
        end
    end

    // Full implies valid, so ev_ready alone decides whether the head frees a slot.
    assign overflow_d = emit & fifo_full & ~ev_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            sync3_q    <= 1'b1;
            state_q    <= S_IDLE;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= kbd_valid;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    event_fifo #(
        .WIDTH (EV_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (emit),
        .wr_data (ev_new),
        .pop     (ev_ready),
        .rd_data (ev_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ev_valid = ~fifo_empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_scancode_decoder.sv
module tb_scancode_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic       ev_ready;
    logic       overflow;

    int n_vec  = 0;
    int n_bad  = 0;
    int n_pops = 0;
    int ov_cnt = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    scancode_decoder #(
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .ev_data   (ev_data),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .overflow  (overflow)
    );

    // One clock: observe at the falling edge, return 1ns after the rising edge.
    task automatic cycle();
        logic [9:0] e;
        @(negedge clk);
        if (overflow) ov_cnt++;
        if (ev_valid && ev_ready) begin
            n_pops++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got %h, no event expected", ev_data);
            end else begin
                e = exp_q.pop_front();
                if (ev_data !== e) begin
                    n_bad++;
                    $display("FAIL event_order: got %h, expected %h", ev_data, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        kbd_valid = 1'b0;
        kbd_data  = b;
        repeat (4) cycle();
        kbd_valid = 1'b1;
        repeat (4) cycle();
    endtask

    task automatic drain_run();
        ev_ready = 1'b1;
        n_pops   = 0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle();
        repeat (3) cycle();
        ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        kbd_valid = 1'b1;
        kbd_data  = 8'h1C;
        ev_ready  = 1'b0;
        repeat (3) cycle();
        n_vec++; if (ev_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_ev_valid: got %b, expected 0", ev_valid); end
        n_vec++; if (overflow !== 1'b0)  begin n_bad++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        n_vec++; if (ev_data !== 10'h0)  begin n_bad++; $display("FAIL reset_ev_data: got %h, expected 000", ev_data); end
        rst = 1'b0;
        repeat (10) cycle();
        n_vec++; if (ev_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_stale_byte: ev_valid got %b, expected 0", ev_valid); end
    endtask

    task automatic test_latency();
        ev_ready  = 1'b0;
        kbd_valid = 1'b0;
        kbd_data  = 8'h1C;
        repeat (4) cycle();
        exp_q.push_back(10'h01C);
        kbd_valid = 1'b1;
        cycle();  // edge N
        n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL latency_n: ev_valid got %b, expected 0", ev_valid); end
        cycle();  // edge N+1
        n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL latency_n1: ev_valid got %b, expected 0", ev_valid); end
        cycle();  // edge N+2
        n_vec++; if (ev_valid !== 1'b1) begin n_bad++; $display("FAIL latency_n2_valid: got %b, expected 1", ev_valid); end
        n_vec++; if (ev_data !== 10'h01C) begin n_bad++; $display("FAIL latency_n2_data: got %h, expected 01c", ev_data); end
        drain_run();
        n_vec++; if (n_pops != 1 || exp_q.size() != 0) begin n_bad++; $display("FAIL latency_count: got %0d events, expected 1", n_pops); end
    endtask

    task automatic test_break();
        exp_q.push_back(10'h11C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        drain_run();
        n_vec++; if (n_pops != 1 || exp_q.size() != 0) begin n_bad++; $display("FAIL break_count: got %0d events, expected 1", n_pops); end
    endtask

    task automatic test_extended();
        exp_q.push_back(10'h275);
        exp_q.push_back(10'h375);
        exp_q.push_back(10'h275);
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hFA); send_byte(8'h75);
        drain_run();
        n_vec++; if (n_pops != 3 || exp_q.size() != 0) begin n_bad++; $display("FAIL extended_count: got %0d events, expected 3", n_pops); end
    endtask

    task automatic test_overflow();
        ev_ready = 1'b0;
        ov_cnt   = 0;
        exp_q.push_back(10'h015);
        exp_q.push_back(10'h01D);
        exp_q.push_back(10'h024);
        exp_q.push_back(10'h02D);
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
        n_vec++; if (ov_cnt != 0) begin n_bad++; $display("FAIL overflow_early: got %0d pulse cycles, expected 0", ov_cnt); end
        send_byte(8'h2C);
        n_vec++; if (ov_cnt != 1) begin n_bad++; $display("FAIL overflow_pulse: got %0d pulse cycles, expected 1", ov_cnt); end
        n_vec++; if (ev_data !== 10'h015) begin n_bad++; $display("FAIL overflow_head: got %h, expected 015", ev_data); end
        drain_run();
        n_vec++; if (n_pops != 4 || exp_q.size() != 0) begin n_bad++; $display("FAIL overflow_drain: got %0d events, expected 4", n_pops); end
    endtask

    task automatic test_back_to_back();
        ev_ready = 1'b0;
        exp_q.push_back(10'h015);
        exp_q.push_back(10'h01D);
        exp_q.push_back(10'h024);
        exp_q.push_back(10'h02D);
        exp_q.push_back(10'h03C);
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
        ov_cnt    = 0;
        kbd_valid = 1'b0;
        kbd_data  = 8'h3C;
        repeat (4) cycle();
        kbd_valid = 1'b1;
        cycle();  // edge N
        cycle();  // edge N+1, strobe cycle follows
        ev_ready = 1'b1;
        cycle();  // edge N+2: pop 0x015 and push 0x03C together
        ev_ready = 1'b0;
        repeat (3) cycle();
        n_vec++; if (ov_cnt != 0) begin n_bad++; $display("FAIL b2b_overflow: got %0d pulse cycles, expected 0", ov_cnt); end
        n_vec++; if (ev_data !== 10'h01D) begin n_bad++; $display("FAIL b2b_head: got %h, expected 01d", ev_data); end
        drain_run();
        n_vec++; if (n_pops != 4 || exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_drain: got %0d events, expected 4", n_pops); end
    endtask

    task automatic test_reset_stale();
        kbd_data  = 8'h1C;
        kbd_valid = 1'b1;
        rst       = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (10) cycle();
        n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL stale_after_reset: ev_valid got %b, expected 0", ev_valid); end
        exp_q.push_back(10'h01C);
        send_byte(8'h1C);
        drain_run();
        n_vec++; if (n_pops != 1 || exp_q.size() != 0) begin n_bad++; $display("FAIL stale_new_frame: got %0d events, expected 1", n_pops); end
    endtask

    task automatic test_reset_prefix();
        send_byte(8'hE0);
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (2) cycle();
        exp_q.push_back(10'h01C);
        send_byte(8'h1C);
        drain_run();
        n_vec++; if (n_pops != 1 || exp_q.size() != 0) begin n_bad++; $display("FAIL prefix_reset: got %0d events, expected 1", n_pops); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_break();
        test_extended();
        test_overflow();
        test_back_to_back();
        test_reset_stale();
        test_reset_prefix();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
